masked_gf16_inverter_pipe: RTL and testbench
============================================

Name: masked_gf16_inverter_pipe

Overview:
- d-share DOM-masked GF(2^4) inverter over a GF(2^2) normal-basis tower, for masked AES S-box datapaths.
- Produces the full 4-bit inverse per share.
- Carries a valid token alongside the data and supports a global pipeline stall.
- Selectable 2- or 3-register-stage depth, fitting 5-staged and 8-staged S-box pipelines.

Parameters:
SHARES, 2, number of Boolean shares (>=2).
EIGHT_STAGED, 0, 0: latency 2 cycles; 1: extra register stage, latency 3 cycles.

Ports:
ClkxCI  in  1  clock, rising edge.
RstxBI  in  1  reset, asynchronous, active-low.
EnxSI  in  1  pipeline enable; 0 = every register holds.
ValidxSI  in  1  input token valid.
XxDI  in  4*SHARES  masked input; share i = bits [4i+3:4i].
Zmul1xDI  in  SHARES*(SHARES-1)  fresh randomness, multiplier 1.
Zmul2xDI  in  SHARES*(SHARES-1)  fresh randomness, multiplier 2.
Zmul3xDI  in  SHARES*(SHARES-1)  fresh randomness, multiplier 3.
ValidxSO  out  1  output token valid.
QxDO  out  4*SHARES  masked inverse; share i = bits [4i+3:4i].

Behaviour:
- Split of each share: A = bits[3:2] (high), B = bits[1:0] (low).
- GF(2^2) mul(a,b): t = (a1^a0)&(b1^b0); q1 = (a1&b1)^t; q0 = (a0&b0)^t.
- sqsc(x) = {x0, x1^x0}.
- inv2(e) = {e0, e1} (bit swap).
- Unmasked function:
  - E = sqsc(A^B) ^ mul(A,B).
  - Q = {mul(inv2(E),B), mul(inv2(E),A)}.
- Linear operations (sqsc, inv2, XOR) are applied share-wise.
- DOM multiplier, per pair i<j:
  - Randomness: Z slice k = 2 bits, k enumerated lexicographically over (i,j) pairs.
  - Cross terms: x_i·y_j^Z_k and x_j·y_i^Z_k.
  - Registered: inner terms x_i·y_i and all cross terms, each in its own register.
  - Output share i = XOR of its inner term plus all cross terms assigned to domain i, taken from registers.
- Stage 1:
  - Mult1 computes A×B using Zmul1 sampled this cycle.
  - Linear part sqsc(A^B) registered per share alongside it.
  - A, B shares registered.
  - E = sqsc_reg ^ mult1_out.
- EIGHT_STAGED=1 only: additional stage registering E, A, B.
- Final stage:
  - Mult2 computes inv2(E)×B; mult3 computes inv2(E)×A.
  - Zmul2/Zmul3 sampled in the cycle the operand E is presented.
  - Output: QxDO share i = {mult2_i, mult3_i}.
- Latency: 2 cycles (EIGHT_STAGED=0) or 3 cycles (EIGHT_STAGED=1), counted in enabled cycles.
- ValidxSO is ValidxSI delayed by the same number of enabled cycles.
- Fully pipelined: accepts one token per enabled cycle.
- EnxSI=0:
  - All data and valid registers hold.
  - Randomness is ignored that cycle.
  - QxDO/ValidxSO are stable.
- Invalid cycles still propagate data; QxDO content is unspecified when ValidxSO=0.
- Reset (asynchronous, any time, including mid-pipeline):
  - All registers clear to 0, so QxDO=0 and ValidxSO=0.
  - In-flight tokens are discarded.
  - First token after release appears exactly after the full latency.
- No combinational path from any input to any output.
- Security: share domains are never XORed before the register stage.
- Each Z bit is used in exactly one cross pair per multiplier and must be fresh for each enabled cycle.

Test Plan:
- Reset: RstxBI=0 with random inputs -> QxDO=0, ValidxSO=0; deassert, apply nothing valid -> ValidxSO stays 0.
- Golden sweep: all 16 X values, SHARES=2 and 3, random masks and random Z every cycle, EnxSI=1, ValidxSI=1 back-to-back:
  - XOR of QxDO shares equals the model after 2 cycles (EIGHT_STAGED=0) or 3 cycles (EIGHT_STAGED=1).
  - X=4'h0 -> 4'h0; X=4'h4 -> 4'h1.
- Mask independence: fixed X=4'h4, 100 random share splits and Z draws -> unmasked output always 4'h1; individual shares vary.
- Stall: stream X=1,2,3 with EnxSI=0 for 3 cycles mid-stream -> outputs unchanged during the stall; sequence resumes in order with no loss or duplication.
- Valid tracking: ValidxSI pattern 1,0,1,1 -> ValidxSO shows the same pattern delayed by the latency.
- Reset mid-operation: assert RstxBI with 2 tokens in flight -> outputs 0 immediately; after release, a new token X=4'h4 yields unmasked 4'h1 with ValidxSO=1 exactly at full latency.

Source files
------------

// File: rtl/masked_gf16_inverter_pipe.sv
// rtl/masked_gf16_inverter_pipe.sv - d-share DOM-masked GF(2^4) inverter, normal-basis GF(2^2) tower.
// Two or three enabled-cycle latency; valid token rides alongside the data.
module masked_gf16_inverter_pipe #(
    parameter int SHARES       = 2,
    parameter int EIGHT_STAGED = 0
) (
    input  logic                         ClkxCI,
    input  logic                         RstxBI,
    input  logic                         EnxSI,
    input  logic                         ValidxSI,
    input  logic [4*SHARES-1:0]          XxDI,
    input  logic [SHARES*(SHARES-1)-1:0] Zmul1xDI,
    input  logic [SHARES*(SHARES-1)-1:0] Zmul2xDI,
    input  logic [SHARES*(SHARES-1)-1:0] Zmul3xDI,
    output logic                         ValidxSO,
    output logic [4*SHARES-1:0]          QxDO
);
    localparam int ZW = SHARES * (SHARES - 1);

    function automatic logic [1:0] gf4_mul(input logic [1:0] a, input logic [1:0] b);
        logic t;
        t = (a[1] ^ a[0]) & (b[1] ^ b[0]);
        return {(a[1] & b[1]) ^ t, (a[0] & b[0]) ^ t};
    endfunction

    function automatic logic [1:0] gf4_sqsc(input logic [1:0] x);
        return {x[0], x[1] ^ x[0]};
    endfunction

    // Both cross terms of pair (i,j) share the same 2-bit slice k (lexicographic over i<j).
    function automatic logic [1:0] z_pair(input logic [ZW-1:0] z, input int i, input int j);
        int lo;
        int hi;
        int k;
        lo = (i < j) ? i : j;
        hi = (i < j) ? j : i;
        k  = lo * SHARES - (lo * (lo + 1)) / 2 + (hi - lo - 1);
        return z[2*k +: 2];
    endfunction

    logic [1:0] w_a    [SHARES];
    logic [1:0] w_b    [SHARES];
    logic [1:0] w_lin  [SHARES];
    logic [1:0] w_m1_d [SHARES][SHARES];
    logic [1:0] r_m1   [SHARES][SHARES];
    logic [1:0] r_lin  [SHARES];
    logic [1:0] r_a1   [SHARES];
    logic [1:0] r_b1   [SHARES];
    logic       r_v1;
    logic [1:0] w_e1   [SHARES];
    logic [1:0] w_e2   [SHARES];
    logic [1:0] w_a2   [SHARES];
    logic [1:0] w_b2   [SHARES];
    logic       w_v2;
    logic [1:0] w_m2_d [SHARES][SHARES];
    logic [1:0] w_m3_d [SHARES][SHARES];
    logic [1:0] r_m2   [SHARES][SHARES];
    logic [1:0] r_m3   [SHARES][SHARES];
    logic       r_v2;
    logic [1:0] w_q_hi [SHARES];
    logic [1:0] w_q_lo [SHARES];

    // Diagonal [i][i] holds the inner term; off-diagonal [i][j] is the cross term owned by domain i.
    always_comb begin
        for (int i = 0; i < SHARES; i++) begin
            w_a[i]   = XxDI[4*i+2 +: 2];
            w_b[i]   = XxDI[4*i +: 2];
            w_lin[i] = gf4_sqsc(w_a[i] ^ w_b[i]);
            for (int j = 0; j < SHARES; j++) begin
                if (i == j) begin
                    w_m1_d[i][j] = gf4_mul(w_a[i], w_b[i]);
                end else begin
                    w_m1_d[i][j] = gf4_mul(w_a[i], w_b[j]) ^ z_pair(Zmul1xDI, i, j);
                end
            end
        end
    end

    always_ff @(posedge ClkxCI or negedge RstxBI) begin
        if (!RstxBI) begin
            r_v1 <= 1'b0;
            for (int i = 0; i < SHARES; i++) begin
                r_lin[i] <= '0;
                r_a1[i]  <= '0;
                r_b1[i]  <= '0;
                for (int j = 0; j < SHARES; j++) begin
                    r_m1[i][j] <= '0;
                end
            end
        end else if (EnxSI) begin
            r_v1 <= ValidxSI;
            for (int i = 0; i < SHARES; i++) begin
                r_lin[i] <= w_lin[i];
                r_a1[i]  <= w_a[i];
                r_b1[i]  <= w_b[i];
                for (int j = 0; j < SHARES; j++) begin
                    r_m1[i][j] <= w_m1_d[i][j];
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < SHARES; i++) begin
            w_e1[i] = r_lin[i];
            for (int j = 0; j < SHARES; j++) begin
                w_e1[i] = w_e1[i] ^ r_m1[i][j];
            end
        end
    end

    if (EIGHT_STAGED != 0) begin : g_stage2
        logic [1:0] r_e [SHARES];
        logic [1:0] r_a [SHARES];
        logic [1:0] r_b [SHARES];
        logic       r_v;

        always_ff @(posedge ClkxCI or negedge RstxBI) begin
            if (!RstxBI) begin
                r_v <= 1'b0;
                for (int i = 0; i < SHARES; i++) begin
                    r_e[i] <= '0;
                    r_a[i] <= '0;
                    r_b[i] <= '0;
                end
            end else if (EnxSI) begin
                r_v <= r_v1;
                for (int i = 0; i < SHARES; i++) begin
                    r_e[i] <= w_e1[i];
                    r_a[i] <= r_a1[i];
                    r_b[i] <= r_b1[i];
                end
            end
        end

        always_comb begin
            for (int i = 0; i < SHARES; i++) begin
                w_e2[i] = r_e[i];
                w_a2[i] = r_a[i];
                w_b2[i] = r_b[i];
            end
        end
        assign w_v2 = r_v;
    end else begin : g_bypass
        always_comb begin
            for (int i = 0; i < SHARES; i++) begin
                w_e2[i] = w_e1[i];
                w_a2[i] = r_a1[i];
                w_b2[i] = r_b1[i];
            end
        end
        assign w_v2 = r_v1;
    end

    always_comb begin
        for (int i = 0; i < SHARES; i++) begin
            for (int j = 0; j < SHARES; j++) begin
                if (i == j) begin
                    w_m2_d[i][j] = gf4_mul({w_e2[i][0], w_e2[i][1]}, w_b2[i]);
                    w_m3_d[i][j] = gf4_mul({w_e2[i][0], w_e2[i][1]}, w_a2[i]);
                end else begin
                    w_m2_d[i][j] = gf4_mul({w_e2[i][0], w_e2[i][1]}, w_b2[j]) ^ z_pair(Zmul2xDI, i, j);
                    w_m3_d[i][j] = gf4_mul({w_e2[i][0], w_e2[i][1]}, w_a2[j]) ^ z_pair(Zmul3xDI, i, j);
                end
            end
        end
    end

    always_ff @(posedge ClkxCI or negedge RstxBI) begin
        if (!RstxBI) begin
            r_v2 <= 1'b0;
            for (int i = 0; i < SHARES; i++) begin
                for (int j = 0; j < SHARES; j++) begin
                    r_m2[i][j] <= '0;
                    r_m3[i][j] <= '0;
                end
            end
        end else if (EnxSI) begin
            r_v2 <= w_v2;
            for (int i = 0; i < SHARES; i++) begin
                for (int j = 0; j < SHARES; j++) begin
                    r_m2[i][j] <= w_m2_d[i][j];
                    r_m3[i][j] <= w_m3_d[i][j];
                end
            end
        end
    end

    always_comb begin
        QxDO = '0;
        for (int i = 0; i < SHARES; i++) begin
            w_q_hi[i] = '0;
            w_q_lo[i] = '0;
            for (int j = 0; j < SHARES; j++) begin
                w_q_hi[i] = w_q_hi[i] ^ r_m2[i][j];
                w_q_lo[i] = w_q_lo[i] ^ r_m3[i][j];
            end
            QxDO[4*i +: 4] = {w_q_hi[i], w_q_lo[i]};
        end
    end

    assign ValidxSO = r_v2;
endmodule

// File: tb/tb_masked_gf16_inverter_pipe.sv
// tb/tb_masked_gf16_inverter_pipe.sv - directed bench for the masked GF(2^4) inverter.
module tb_masked_gf16_inverter_pipe;
    logic        clk;
    logic        rstn;
    logic        en;
    logic        vin;
    logic [7:0]  x2;
    logic [11:0] x3;
    logic [1:0]  z1_2, z2_2, z3_2;
    logic [5:0]  z1_3, z2_3, z3_3;
    logic        v2, v3;
    logic [7:0]  q2;
    logic [11:0] q3;
    int          n_vec;
    int          n_err;

    masked_gf16_inverter_pipe #(.SHARES(2), .EIGHT_STAGED(0)) u_dut2 (
        .ClkxCI(clk), .RstxBI(rstn), .EnxSI(en), .ValidxSI(vin), .XxDI(x2),
        .Zmul1xDI(z1_2), .Zmul2xDI(z2_2), .Zmul3xDI(z3_2), .ValidxSO(v2), .QxDO(q2)
    );

    masked_gf16_inverter_pipe #(.SHARES(3), .EIGHT_STAGED(1)) u_dut3 (
        .ClkxCI(clk), .RstxBI(rstn), .EnxSI(en), .ValidxSI(vin), .XxDI(x3),
        .Zmul1xDI(z1_3), .Zmul2xDI(z2_3), .Zmul3xDI(z3_3), .ValidxSO(v3), .QxDO(q3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [1:0] m_mul(input logic [1:0] a, input logic [1:0] b);
        logic t;
        t = (a[1] ^ a[0]) & (b[1] ^ b[0]);
        return {(a[1] & b[1]) ^ t, (a[0] & b[0]) ^ t};
    endfunction

    function automatic logic [3:0] model(input logic [3:0] x);
        logic [1:0] a, b, s, e, ie;
        a  = x[3:2];
        b  = x[1:0];
        s  = a ^ b;
        e  = {s[0], s[1] ^ s[0]} ^ m_mul(a, b);
        ie = {e[0], e[1]};
        return {m_mul(ie, b), m_mul(ie, a)};
    endfunction

    function automatic logic [3:0] u2(input logic [7:0] q);
        return q[7:4] ^ q[3:0];
    endfunction

    function automatic logic [3:0] u3(input logic [11:0] q);
        return q[11:8] ^ q[7:4] ^ q[3:0];
    endfunction

    task automatic drive(input logic [3:0] x, input logic v, input logic e);
        logic [3:0] r1, r2;
        r1   = 4'($urandom);
        r2   = 4'($urandom);
        x2   = {r1, r1 ^ x};
        x3   = {r1, r2, r1 ^ r2 ^ x};
        z1_2 = 2'($urandom);
        z2_2 = 2'($urandom);
        z3_2 = 2'($urandom);
        z1_3 = 6'($urandom);
        z2_3 = 6'($urandom);
        z3_3 = 6'($urandom);
        vin  = v;
        en   = e;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        for (int m = 0; m < 3; m++) drive(4'($urandom), 1'b1, 1'b1);
        n_vec += 4;
        if (q2 !== 8'h00)  begin n_err++; $display("FAIL reset_q2 got=%h exp=00", q2); end
        if (v2 !== 1'b0)   begin n_err++; $display("FAIL reset_v2 got=%b exp=0", v2); end
        if (q3 !== 12'h0)  begin n_err++; $display("FAIL reset_q3 got=%h exp=000", q3); end
        if (v3 !== 1'b0)   begin n_err++; $display("FAIL reset_v3 got=%b exp=0", v3); end
        rstn = 1'b1;
        for (int m = 0; m < 4; m++) begin
            drive(4'($urandom), 1'b0, 1'b1);
            n_vec += 2;
            if (v2 !== 1'b0) begin n_err++; $display("FAIL idle_v2 cyc=%0d got=%b exp=0", m, v2); end
            if (v3 !== 1'b0) begin n_err++; $display("FAIL idle_v3 cyc=%0d got=%b exp=0", m, v3); end
        end
    endtask

    task automatic test_golden_sweep();
        logic [3:0] xi;
        for (int m = 0; m < 18; m++) begin
            if (m < 16) drive(4'(m), 1'b1, 1'b1);
            else        drive(4'h0, 1'b0, 1'b1);
            if (m >= 1 && m <= 16) begin
                xi = 4'(m - 1);
                n_vec += 2;
                if (u2(q2) !== model(xi)) begin n_err++; $display("FAIL sweep2 x=%h got=%h exp=%h", xi, u2(q2), model(xi)); end
                if (v2 !== 1'b1) begin n_err++; $display("FAIL sweep2_valid x=%h got=%b exp=1", xi, v2); end
                if (xi == 4'h0) begin
                    n_vec++;
                    if (u2(q2) !== 4'h0) begin n_err++; $display("FAIL inv0_2 got=%h exp=0", u2(q2)); end
                end
                if (xi == 4'h4) begin
                    n_vec++;
                    if (u2(q2) !== 4'h1) begin n_err++; $display("FAIL inv4_2 got=%h exp=1", u2(q2)); end
                end
                if (xi == 4'h1) begin
                    n_vec++;
                    if (u2(q2) !== 4'h4) begin n_err++; $display("FAIL inv1_2 got=%h exp=4", u2(q2)); end
                end
            end
            if (m >= 2) begin
                xi = 4'(m - 2);
                n_vec += 2;
                if (u3(q3) !== model(xi)) begin n_err++; $display("FAIL sweep3 x=%h got=%h exp=%h", xi, u3(q3), model(xi)); end
                if (v3 !== 1'b1) begin n_err++; $display("FAIL sweep3_valid x=%h got=%b exp=1", xi, v3); end
                if (xi == 4'h4) begin
                    n_vec++;
                    if (u3(q3) !== 4'h1) begin n_err++; $display("FAIL inv4_3 got=%h exp=1", u3(q3)); end
                end
            end
        end
    endtask

    task automatic test_mask_independence();
        logic [3:0] first_share;
        logic       varied;
        varied      = 1'b0;
        first_share = 4'h0;
        for (int m = 0; m < 102; m++) begin
            if (m < 100) drive(4'h4, 1'b1, 1'b1);
            else         drive(4'h0, 1'b0, 1'b1);
            if (m >= 1 && m <= 100) begin
                n_vec++;
                if (u2(q2) !== 4'h1) begin n_err++; $display("FAIL mask2 iter=%0d got=%h exp=1", m, u2(q2)); end
                if (m == 1) first_share = q2[3:0];
                else if (q2[3:0] != first_share) varied = 1'b1;
            end
            if (m >= 2) begin
                n_vec++;
                if (u3(q3) !== 4'h1) begin n_err++; $display("FAIL mask3 iter=%0d got=%h exp=1", m, u3(q3)); end
            end
        end
        n_vec++;
        if (varied !== 1'b1) begin n_err++; $display("FAIL mask_share_vary got=%b exp=1", varied); end
    endtask

    task automatic test_stall();
        logic [3:0] xt [9];
        logic       vt [9];
        logic       et [9];
        logic       ev2 [9];
        logic [3:0] ex2 [9];
        logic       ev3 [9];
        logic [3:0] ex3 [9];
        xt  = '{4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3, 4'd0, 4'd0, 4'd0};
        vt  = '{1, 1, 1, 1, 1, 1, 0, 0, 0};
        et  = '{1, 1, 0, 0, 0, 1, 1, 1, 1};
        ev2 = '{0, 1, 1, 1, 1, 1, 1, 0, 0};
        ex2 = '{4'd0, 4'd1, 4'd1, 4'd1, 4'd1, 4'd2, 4'd3, 4'd0, 4'd0};
        ev3 = '{0, 0, 0, 0, 0, 1, 1, 1, 0};
        ex3 = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd0};
        for (int m = 0; m < 3; m++) drive(4'h0, 1'b0, 1'b1);
        for (int m = 0; m < 9; m++) begin
            drive(xt[m], vt[m], et[m]);
            n_vec += 2;
            if (v2 !== ev2[m]) begin n_err++; $display("FAIL stall_v2 cyc=%0d got=%b exp=%b", m, v2, ev2[m]); end
            if (v3 !== ev3[m]) begin n_err++; $display("FAIL stall_v3 cyc=%0d got=%b exp=%b", m, v3, ev3[m]); end
            if (ev2[m]) begin
                n_vec++;
                if (u2(q2) !== model(ex2[m])) begin n_err++; $display("FAIL stall_q2 cyc=%0d got=%h exp=%h", m, u2(q2), model(ex2[m])); end
            end
            if (ev3[m]) begin
                n_vec++;
                if (u3(q3) !== model(ex3[m])) begin n_err++; $display("FAIL stall_q3 cyc=%0d got=%h exp=%h", m, u3(q3), model(ex3[m])); end
            end
        end
    endtask

    task automatic test_valid_tracking();
        logic [3:0] xt [7];
        logic       vt [7];
        logic       e2, e3;
        xt = '{4'd5, 4'd6, 4'd7, 4'd8, 4'd0, 4'd0, 4'd0};
        vt = '{1, 0, 1, 1, 0, 0, 0};
        for (int m = 0; m < 7; m++) begin
            drive(xt[m], vt[m], 1'b1);
            e2 = (m >= 1) ? vt[m-1] : 1'b0;
            e3 = (m >= 2) ? vt[m-2] : 1'b0;
            n_vec += 2;
            if (v2 !== e2) begin n_err++; $display("FAIL valid_v2 cyc=%0d got=%b exp=%b", m, v2, e2); end
            if (v3 !== e3) begin n_err++; $display("FAIL valid_v3 cyc=%0d got=%b exp=%b", m, v3, e3); end
            if (e2) begin
                n_vec++;
                if (u2(q2) !== model(xt[m-1])) begin n_err++; $display("FAIL valid_q2 cyc=%0d got=%h exp=%h", m, u2(q2), model(xt[m-1])); end
            end
            if (e3) begin
                n_vec++;
                if (u3(q3) !== model(xt[m-2])) begin n_err++; $display("FAIL valid_q3 cyc=%0d got=%h exp=%h", m, u3(q3), model(xt[m-2])); end
            end
        end
    endtask

    task automatic test_reset_midop();
        drive(4'd9, 1'b1, 1'b1);
        drive(4'd10, 1'b1, 1'b1);
        #2;
        rstn = 1'b0;
        #1;
        n_vec += 4;
        if (q2 !== 8'h00) begin n_err++; $display("FAIL midrst_q2 got=%h exp=00", q2); end
        if (v2 !== 1'b0)  begin n_err++; $display("FAIL midrst_v2 got=%b exp=0", v2); end
        if (q3 !== 12'h0) begin n_err++; $display("FAIL midrst_q3 got=%h exp=000", q3); end
        if (v3 !== 1'b0)  begin n_err++; $display("FAIL midrst_v3 got=%b exp=0", v3); end
        @(posedge clk);
        #1;
        rstn = 1'b1;
        drive(4'h4, 1'b1, 1'b1);
        n_vec += 2;
        if (v2 !== 1'b0) begin n_err++; $display("FAIL post_rst_v2_c1 got=%b exp=0", v2); end
        if (v3 !== 1'b0) begin n_err++; $display("FAIL post_rst_v3_c1 got=%b exp=0", v3); end
        drive(4'h0, 1'b0, 1'b1);
        n_vec += 3;
        if (v2 !== 1'b1)     begin n_err++; $display("FAIL post_rst_v2_c2 got=%b exp=1", v2); end
        if (u2(q2) !== 4'h1) begin n_err++; $display("FAIL post_rst_q2 got=%h exp=1", u2(q2)); end
        if (v3 !== 1'b0)     begin n_err++; $display("FAIL post_rst_v3_c2 got=%b exp=0", v3); end
        drive(4'h0, 1'b0, 1'b1);
        n_vec += 3;
        if (v2 !== 1'b0)     begin n_err++; $display("FAIL post_rst_v2_c3 got=%b exp=0", v2); end
        if (v3 !== 1'b1)     begin n_err++; $display("FAIL post_rst_v3_c3 got=%b exp=1", v3); end
        if (u3(q3) !== 4'h1) begin n_err++; $display("FAIL post_rst_q3 got=%h exp=1", u3(q3)); end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rstn  = 1'b0;
        en    = 1'b0;
        vin   = 1'b0;
        x2    = '0;
        x3    = '0;
        z1_2  = '0; z2_2 = '0; z3_2 = '0;
        z1_3  = '0; z2_3 = '0; z3_3 = '0;
        #1;
        test_reset();
        test_golden_sweep();
        test_mask_independence();
        test_stall();
        test_valid_tracking();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
